// File: rtl/mem_arbiter_n_pkg.sv
// Shared definitions for the N-port byte-serial memory arbiter: FSM encoding,
// IO window decode, length clamping and the bus pause rule.
package mem_arbiter_n_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2
    } state_t;

    // IO space lives where addr[17:16] == IO_BASE; reads issue once per byte so no special path.
    localparam logic [1:0] IO_BASE    = 2'b11;
    localparam int         IO_SEL_LSB = 16;

    function automatic logic is_io(input logic [1:0] sel);
        return sel == IO_BASE;
    endfunction

    // Lengths above the bus capacity are treated as a full-width transfer.
    function automatic int clamp_len(input int len, input int max_bytes);
        return (len > max_bytes) ? max_bytes : len;
    endfunction

    // The write strobe is only visible on the pins while the global pause is released.
    function automatic logic wr_strobe(input logic wr_reg, input logic rdy);
        return wr_reg & rdy;
    endfunction

endpackage

// File: rtl/mem_arbiter_n_rr_arbiter.sv
// Request arbiter: one-hot grant from a request mask, round-robin or fixed
// lowest-index priority. The pointer only moves when the grant is accepted.
module mem_arbiter_n_rr_arbiter #(
    parameter int NUM_PORTS  = 2,
    parameter int FIXED_PRIO = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_PORTS-1:0] req,
    input  logic                 accept,
    output logic [NUM_PORTS-1:0] grant
);

    localparam int PTR_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    logic [PTR_W-1:0] ptr_reg;
    logic             found;
    int               idx;

    // Scan starting at the pointer; the first requester found wins.
    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            idx = (FIXED_PRIO != 0) ? k : (int'(ptr_reg) + k) % NUM_PORTS;
            for (int p = 0; p < NUM_PORTS; p++) begin
                if (!found && (p == idx) && req[p]) begin
                    grant[p] = 1'b1;
                    found    = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_reg <= '0;
        end else if (accept) begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                if (grant[p]) begin
                    ptr_reg <= PTR_W'((p + 1) % NUM_PORTS);
                end
            end
        end
    end

endmodule

// File: rtl/mem_arbiter_n.sv
// N-requester memory arbiter onto the byte-serial RAM/IO bus: 0..MAX_BYTES byte
// reads (one address issued per cycle, data one cycle later) and writes.
module mem_arbiter_n
    import mem_arbiter_n_pkg::*;
#(
    parameter int NUM_PORTS  = 2,
    parameter int ADDR_W     = 32,
    parameter int MAX_BYTES  = 4,
    parameter int LEN_W      = 3,
    parameter int FIXED_PRIO = 0
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           rdy,
    input  logic [NUM_PORTS-1:0]           req_i,
    input  logic [NUM_PORTS-1:0]           wr_i,
    input  logic [NUM_PORTS-1:0]           cancel_i,
    input  logic [NUM_PORTS*ADDR_W-1:0]    addr_i,
    input  logic [NUM_PORTS*LEN_W-1:0]     len_i,
    input  logic [NUM_PORTS*8*MAX_BYTES-1:0] wdata_i,
    output logic [NUM_PORTS-1:0]           done_o,
    output logic [8*MAX_BYTES-1:0]         rdata_o,
    output logic                           busy_o,
    input  logic [7:0]                     mem_din,
    output logic [7:0]                     mem_dout,
    output logic [ADDR_W-1:0]              mem_a,
    output logic                           mem_wr
);

    localparam int DW = 8 * MAX_BYTES;

    logic [ADDR_W-1:0] port_addr  [NUM_PORTS];
    logic [LEN_W-1:0]  port_len   [NUM_PORTS];
    logic [DW-1:0]     port_wdata [NUM_PORTS];

    generate
        for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_port
            assign port_addr[gi]  = addr_i[gi*ADDR_W +: ADDR_W];
            assign port_len[gi]   = len_i[gi*LEN_W +: LEN_W];
            assign port_wdata[gi] = wdata_i[gi*DW +: DW];
        end
    endgenerate

    state_t               state_reg;
    logic [NUM_PORTS-1:0] port_reg;
    logic [ADDR_W-1:0]    addr_reg;
    logic [LEN_W-1:0]     len_reg;
    logic [DW-1:0]        wdata_reg;
    logic [LEN_W-1:0]     issue_cnt_reg;
    logic [LEN_W-1:0]     cap_cnt_reg;
    logic                 pend_reg;
    logic [DW-1:0]        rbuf_reg;
    logic [NUM_PORTS-1:0] done_reg;
    logic [DW-1:0]        rdata_reg;
    logic                 busy_reg;
    logic [ADDR_W-1:0]    mem_a_reg;
    logic [7:0]           mem_dout_reg;
    logic                 mem_wr_reg;

    logic [NUM_PORTS-1:0] req_mask;
    logic [NUM_PORTS-1:0] grant;
    logic                 accept;
    logic [ADDR_W-1:0]    sel_addr;
    logic [LEN_W-1:0]     sel_len_raw;
    logic [LEN_W-1:0]     sel_len;
    logic [DW-1:0]        sel_wdata;
    logic                 sel_wr;
    logic                 cancel_hit;
    logic                 issue_now;
    logic [LEN_W-1:0]     cnt_next;
    logic [LEN_W-1:0]     cap_total;
    logic [7:0]           wbyte_next;
    logic [DW-1:0]        rbuf_next;

    // A port whose done_o is pulsing still has req_i high this cycle; keep it out.
    assign req_mask = req_i & ~done_reg;
    assign accept   = (state_reg == ST_IDLE) && rdy && (|grant);

    mem_arbiter_n_rr_arbiter #(
        .NUM_PORTS  (NUM_PORTS),
        .FIXED_PRIO (FIXED_PRIO)
    ) u_arb (
        .clk    (clk),
        .rst    (rst),
        .req    (req_mask),
        .accept (accept),
        .grant  (grant)
    );

    always_comb begin
        sel_addr    = '0;
        sel_len_raw = '0;
        sel_wdata   = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (grant[p]) begin
                sel_addr    = port_addr[p];
                sel_len_raw = port_len[p];
                sel_wdata   = port_wdata[p];
            end
        end
    end

    assign sel_wr     = |(grant & wr_i);
    assign sel_len    = LEN_W'(clamp_len(int'(sel_len_raw), MAX_BYTES));
    assign cancel_hit = |(cancel_i & port_reg);
    assign issue_now  = (state_reg == ST_READ) && rdy && (issue_cnt_reg < len_reg);
    assign cnt_next   = issue_cnt_reg + LEN_W'(1);
    assign cap_total  = cap_cnt_reg + LEN_W'(pend_reg);

    // pend_reg marks that mem_din this cycle answers last cycle's issue; capture it in order.
    always_comb begin
        rbuf_next  = rbuf_reg;
        wbyte_next = '0;
        for (int b = 0; b < MAX_BYTES; b++) begin
            if (pend_reg && (cap_cnt_reg == LEN_W'(b))) begin
                rbuf_next[8*b +: 8] = mem_din;
            end
            if (cnt_next == LEN_W'(b)) begin
                wbyte_next = wdata_reg[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            port_reg      <= '0;
            addr_reg      <= '0;
            len_reg       <= '0;
            wdata_reg     <= '0;
            issue_cnt_reg <= '0;
            cap_cnt_reg   <= '0;
            pend_reg      <= 1'b0;
            rbuf_reg      <= '0;
            done_reg      <= '0;
            rdata_reg     <= '0;
            busy_reg      <= 1'b0;
            mem_a_reg     <= '0;
            mem_dout_reg  <= '0;
            mem_wr_reg    <= 1'b0;
        end else begin
            done_reg <= '0;
            case (state_reg)
                ST_IDLE: begin
                    if (accept) begin
                        port_reg      <= grant;
                        addr_reg      <= sel_addr;
                        len_reg       <= sel_len;
                        wdata_reg     <= sel_wdata;
                        issue_cnt_reg <= '0;
                        cap_cnt_reg   <= '0;
                        pend_reg      <= 1'b0;
                        rbuf_reg      <= '0;
                        if (sel_len == '0) begin
                            done_reg  <= grant;
                            rdata_reg <= '0;
                        end else begin
                            busy_reg   <= 1'b1;
                            mem_a_reg  <= sel_addr;
                            mem_wr_reg <= sel_wr;
                            state_reg  <= sel_wr ? ST_WRITE : ST_READ;
                            if (sel_wr) begin
                                mem_dout_reg <= sel_wdata[7:0];
                            end
                        end
                    end
                end
                ST_READ: begin
                    // Data for an address issued just before a pause is still taken.
                    if (pend_reg) begin
                        rbuf_reg    <= rbuf_next;
                        cap_cnt_reg <= cap_cnt_reg + LEN_W'(1);
                    end
                    pend_reg <= issue_now;
                    if (rdy) begin
                        if (cancel_hit) begin
                            pend_reg  <= 1'b0;
                            busy_reg  <= 1'b0;
                            state_reg <= ST_IDLE;
                        end else if (cap_total == len_reg) begin
                            done_reg  <= port_reg;
                            rdata_reg <= rbuf_next;
                            busy_reg  <= 1'b0;
                            state_reg <= ST_IDLE;
                        end else if (issue_now) begin
                            issue_cnt_reg <= cnt_next;
                            if (cnt_next != len_reg) begin
                                mem_a_reg <= addr_reg + ADDR_W'(cnt_next);
                            end
                        end
                    end
                end
                ST_WRITE: begin
                    if (rdy) begin
                        issue_cnt_reg <= cnt_next;
                        if (cnt_next == len_reg) begin
                            done_reg   <= port_reg;
                            rdata_reg  <= '0;
                            busy_reg   <= 1'b0;
                            mem_wr_reg <= 1'b0;
                            state_reg  <= ST_IDLE;
                        end else begin
                            mem_a_reg    <= addr_reg + ADDR_W'(cnt_next);
                            mem_dout_reg <= wbyte_next;
                        end
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign done_o   = done_reg;
    assign rdata_o  = rdata_reg;
    assign busy_o   = busy_reg;
    assign mem_a    = mem_a_reg;
    assign mem_dout = mem_dout_reg;
    assign mem_wr   = wr_strobe(mem_wr_reg, rdy);

endmodule

// File: tb/tb_mem_arbiter_n.sv
// Directed bench for mem_arbiter_n: a vector table of single-port transfers plus
// hand-written sequences for alternation, cancel, pause and mid-transfer reset.
module tb_mem_arbiter_n;

    logic        clk;
    logic        rst;
    logic        rdy;
    logic [1:0]  req;
    logic [1:0]  wr;
    logic [1:0]  cancel;
    logic [63:0] addr_v;
    logic [5:0]  len_v;
    logic [63:0] wdata_v;
    logic [1:0]  done_o;
    logic [31:0] rdata_o;
    logic        busy_o;
    logic [7:0]  mem_din;
    logic [7:0]  mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;

    int pass_cnt  = 0;
    int total_cnt = 0;

    mem_arbiter_n #(
        .NUM_PORTS  (2),
        .ADDR_W     (32),
        .MAX_BYTES  (4),
        .LEN_W      (3),
        .FIXED_PRIO (0)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .rdy      (rdy),
        .req_i    (req),
        .wr_i     (wr),
        .cancel_i (cancel),
        .addr_i   (addr_v),
        .len_i    (len_v),
        .wdata_i  (wdata_v),
        .done_o   (done_o),
        .rdata_o  (rdata_o),
        .busy_o   (busy_o),
        .mem_din  (mem_din),
        .mem_dout (mem_dout),
        .mem_a    (mem_a),
        .mem_wr   (mem_wr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Registered-read RAM: a few fixed bytes at 0x100, a simple pattern elsewhere.
    function automatic logic [7:0] ram_byte(input logic [31:0] a);
        case (a)
            32'h100: return 8'h11;
            32'h101: return 8'h22;
            32'h102: return 8'h33;
            32'h103: return 8'h44;
            default: return a[7:0] ^ 8'hA5;
        endcase
    endfunction

    always @(posedge clk) mem_din <= ram_byte(mem_a);

    typedef struct {
        int          port;
        bit          wr;
        logic [31:0] addr;
        int          len;
        logic [31:0] wdata;
        int          done_cyc;
        logic [31:0] rdata;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic set_port(input int p, input bit w, input logic [31:0] a, input int n,
                            input logic [31:0] d);
        wr[p]                 = w;
        addr_v[p*32 +: 32]    = a;
        len_v[p*3 +: 3]       = 3'(n);
        wdata_v[p*32 +: 32]   = d;
    endtask

    // Called at a negedge that is cycle 0 for the transfer.
    task automatic run_vec(input int n, input vec_t v);
        int          got_done;
        logic [1:0]  got_vec;
        logic [31:0] got_rdata;
        logic [31:0] ea;
        logic [31:0] sh;
        got_done  = -1;
        got_vec   = '0;
        got_rdata = '0;
        set_port(v.port, v.wr, v.addr, v.len, v.wdata);
        req = '0;
        req[v.port] = 1'b1;
        for (int c = 1; c <= v.done_cyc + 3; c++) begin
            @(negedge clk);
            ea = v.addr + 32'(c - 1);
            if (c <= v.len) begin
                if (v.wr) begin
                    sh = v.wdata >> (8 * (c - 1));
                    chk("wr_bus", {mem_wr, mem_a, mem_dout}, {1'b1, ea, sh[7:0]});
                end else begin
                    chk("rd_bus", {mem_wr, mem_a}, {1'b0, ea});
                end
            end
            if (c == 1) chk("busy_c1", busy_o, (v.len > 0) ? 1 : 0);
            if (v.len == 0 && c == 1) chk("len0_quiet", mem_wr, 0);
            if (done_o != 2'b00 && got_done < 0) begin
                got_done  = c;
                got_vec   = done_o;
                got_rdata = rdata_o;
                req       = '0;
            end
        end
        req = '0;
        chk("done_cycle", got_done, v.done_cyc);
        chk("done_port", got_vec, 2'b01 << v.port);
        if (!v.wr) chk("rdata", got_rdata, v.rdata);
        $display("vec %0d: port %0d %s addr 0x%08h len %0d done@%0d rdata 0x%08h",
                 n, v.port, v.wr ? "WR" : "RD", v.addr, v.len, got_done, got_rdata);
    endtask

    initial begin
        int          seen_done0;
        int          got_done;
        int          k;
        logic [31:0] got_rdata;
        logic [31:0] exp_a [6];

        rst = 1'b1; rdy = 1'b1; req = '0; wr = '0; cancel = '0;
        addr_v = '0; len_v = '0; wdata_v = '0;

        vecs[0] = '{1, 1'b0, 32'h0000_0100, 4, 32'h0,          6, 32'h4433_2211};
        vecs[1] = '{1, 1'b1, 32'h0003_0000, 1, 32'h41,         2, 32'h0};
        vecs[2] = '{0, 1'b0, 32'h0000_01FF, 2, 32'h0,          4, 32'h0000_A55A};
        vecs[3] = '{0, 1'b1, 32'hFFFF_FFFF, 3, 32'h00CC_BBAA,  4, 32'h0};
        vecs[4] = '{1, 1'b0, 32'hFFFF_FFFE, 3, 32'h0,          5, 32'h00A5_5A5B};
        vecs[5] = '{0, 1'b0, 32'h0000_0050, 0, 32'h0,          1, 32'h0};
        vecs[6] = '{1, 1'b1, 32'h0000_0060, 0, 32'h5555_5555,  1, 32'h0};
        vecs[7] = '{0, 1'b0, 32'h0003_0000, 1, 32'h0,          3, 32'h0000_00A5};

        repeat (3) @(negedge clk);
        chk("rst_done",  done_o,   0);
        chk("rst_rdata", rdata_o,  0);
        chk("rst_busy",  busy_o,   0);
        chk("rst_wr",    mem_wr,   0);
        chk("rst_a",     mem_a,    0);
        chk("rst_dout",  mem_dout, 0);
        $display("reset: done %b busy %b mem_a 0x%08h", done_o, busy_o, mem_a);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 8; i++) run_vec(i, vecs[i]);

        // Both ports request continuously: grants must alternate starting at port 0.
        do_reset();
        set_port(0, 1'b0, 32'h100, 1, 32'h0);
        set_port(1, 1'b0, 32'h102, 1, 32'h0);
        req = 2'b11;
        k = 0;
        for (int c = 0; c < 60 && k < 4; c++) begin
            @(negedge clk);
            if (done_o != 2'b00) begin
                chk("alt_grant", done_o, (k % 2 == 0) ? 2'b01 : 2'b10);
                chk("alt_rdata", rdata_o, (k % 2 == 0) ? 32'h11 : 32'h33);
                $display("alt %0d: done %b rdata 0x%08h", k, done_o, rdata_o);
                k++;
            end
        end
        req = '0;
        chk("alt_count", k, 4);
        repeat (3) @(negedge clk);

        // Cancel port 0's 4-byte read in cycle 2; port 1 takes the next IDLE.
        set_port(0, 1'b0, 32'h100, 4, 32'h0);
        set_port(1, 1'b0, 32'h103, 1, 32'h0);
        req = 2'b01;
        seen_done0 = 0;
        got_done = -1;
        got_rdata = '0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (done_o[0]) seen_done0++;
            if (done_o[1] && got_done < 0) begin
                got_done  = c;
                got_rdata = rdata_o;
                req[1]    = 1'b0;
            end
            case (c)
                1: begin chk("cxl_a1", mem_a, 32'h100); req[1] = 1'b1; end
                2: begin chk("cxl_a2", mem_a, 32'h101); cancel[0] = 1'b1; end
                3: begin
                    chk("cxl_hold", mem_a, 32'h101);
                    chk("cxl_busy", busy_o, 0);
                    cancel[0] = 1'b0;
                    req[0] = 1'b0;
                end
                4: chk("cxl_p1_a", mem_a, 32'h103);
                default: ;
            endcase
        end
        req = '0;
        chk("cxl_no_done0", seen_done0, 0);
        chk("cxl_p1_done", got_done, 6);
        chk("cxl_p1_rdata", got_rdata, 32'h44);
        $display("cancel: port1 done@%0d rdata 0x%08h", got_done, got_rdata);
        repeat (2) @(negedge clk);

        // Pause in cycles 2-3 of a 4-byte read.
        exp_a = '{32'h100, 32'h101, 32'h101, 32'h101, 32'h102, 32'h103};
        set_port(0, 1'b0, 32'h100, 4, 32'h0);
        req = 2'b01;
        got_done = -1;
        got_rdata = '0;
        for (int c = 1; c <= 11; c++) begin
            @(negedge clk);
            if (c <= 6) chk("rdy_a", mem_a, exp_a[c-1]);
            if (done_o != 2'b00 && got_done < 0) begin
                got_done  = c;
                got_rdata = rdata_o;
                req       = '0;
            end
            if (c == 2) rdy = 1'b0;
            if (c == 4) rdy = 1'b1;
        end
        req = '0;
        chk("rdy_done", got_done, 8);
        chk("rdy_rdata", got_rdata, 32'h4433_2211);
        $display("pause: done@%0d rdata 0x%08h", got_done, got_rdata);
        repeat (2) @(negedge clk);

        // Reset arrives in cycle 3 of a 4-byte write.
        set_port(0, 1'b1, 32'h200, 4, 32'hDDCC_BBAA);
        req = 2'b01;
        got_done = 0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (c <= 3) chk("rstw_bus", {mem_wr, mem_a}, {1'b1, 32'h200 + 32'(c - 1)});
            if (c == 3) rst = 1'b1;
            if (c == 4) begin
                chk("rstw_wr", mem_wr, 0);
                chk("rstw_busy", busy_o, 0);
                rst = 1'b0;
                req = '0;
            end
            if (done_o != 2'b00) got_done++;
        end
        chk("rstw_no_done", got_done, 0);
        $display("reset mid-write: done pulses %0d", got_done);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
